// File: rtl/aud_recorder_ms_if.sv
`default_nettype none
// ============================================================================
//  Module      : aud_recorder_ms_if
//  Description : SRAM write bus and status from the I2S recorder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aud_recorder_ms_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 20
) ();
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic              we;
   logic [ADDR_W:0]   len;
   logic              busy;
   logic              full;

   modport master (
      output address,
      output data,
      output we,
      output len,
      output busy,
      output full
   );

   modport slave (
      input address,
      input data,
      input we,
      input len,
      input busy,
      input full
   );
endinterface
`default_nettype wire

// File: rtl/aud_recorder_ms.sv
`default_nettype none
// ============================================================================
//  Module      : aud_recorder_ms
//  Description : I2S deserialiser feeding an SRAM writer, frame-aligned pause.
//                Define AUD_REC_STEREO_EN to record both channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_recorder_ms #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  wire logic          i_clk,
   input  wire logic          i_rst_n,
   input  wire logic          i_lrc,
   input  wire logic          i_data,
   input  wire logic          i_start,
   input  wire logic          i_pause,
   input  wire logic          i_stop,
   aud_recorder_ms_if.master  wr
);

`ifdef AUD_REC_STEREO_EN
   localparam logic c_stereo = 1'b1;
`else
   localparam logic c_stereo = 1'b0;
`endif

   localparam int               CNT_W      = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] c_cnt_done = CNT_W'(DATA_W);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_PAUSED  = 2'd3
   } state_t;

   state_t              r_state;
   logic                r_lrc_q;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic [DATA_W-2:0]   r_shift;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]   r_address;
   logic [DATA_W-1:0]   r_data;
   logic                r_we;
   logic [ADDR_W:0]     r_len;
   logic                r_busy;
   logic                r_full;
   logic                r_pause_pend;

   logic                w_edge;
   logic                w_fall;
   logic                w_sample;
   logic                w_last;
   logic                w_chan_ok;
   logic [DATA_W-1:0]   w_word;

   assign w_edge    = (i_lrc != r_lrc_q);
   assign w_fall    = r_lrc_q & ~i_lrc;
   assign w_sample  = ~w_edge && (r_bit_cnt != c_cnt_done);
   assign w_last    = w_sample && (r_bit_cnt == c_cnt_last);
   // Mono builds only keep the left half-frame (r_lrc_q low once past the edge)
   assign w_chan_ok = c_stereo | ~r_lrc_q;
   assign w_word    = {r_shift, i_data};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_lrc_q      <= 1'b0;
         r_bit_cnt    <= c_cnt_done;
         r_shift      <= '0;
         r_ptr        <= '0;
         r_address    <= '0;
         r_data       <= '0;
         r_we         <= 1'b0;
         r_len        <= '0;
         r_busy       <= 1'b0;
         r_full       <= 1'b0;
         r_pause_pend <= 1'b0;
      end else begin
         r_lrc_q <= i_lrc;
         r_we    <= 1'b0;

         if (w_edge) begin
            r_bit_cnt <= '0;
         end else if (w_sample) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
         end

         if (w_sample) begin
            r_shift <= w_word[DATA_W-2:0];
         end

         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_ptr   <= '0;
                  r_len   <= '0;
                  r_full  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (i_stop) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (i_pause) begin
                  r_state <= ST_PAUSED;
               end else if (w_fall) begin
                  r_state <= ST_CAPTURE;
               end
            end

            ST_CAPTURE: begin
               if (i_stop) begin
                  r_pause_pend <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= ST_IDLE;
               end else begin
                  if (i_pause) begin
                     r_pause_pend <= 1'b1;
                  end
                  if (w_last && w_chan_ok) begin
                     r_we      <= 1'b1;
                     r_address <= r_ptr;
                     r_data    <= w_word;
                     r_ptr     <= r_ptr + ADDR_W'(1);
                     r_len     <= r_len + (ADDR_W+1)'(1);
                     if (r_ptr == MAX_ADDR) begin
                        r_full       <= 1'b1;
                        r_pause_pend <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                     end
                  end else if (w_fall && (r_pause_pend || i_pause)) begin
                     // Pausing only on a left-channel start keeps stereo pairs together
                     r_pause_pend <= 1'b0;
                     r_state      <= ST_PAUSED;
                  end
               end
            end

            ST_PAUSED: begin
               if (i_stop) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (i_start) begin
                  r_state <= ST_WAIT;
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign wr.address = r_address;
   assign wr.data    = r_data;
   assign wr.we      = r_we;
   assign wr.len     = r_len;
   assign wr.busy    = r_busy;
   assign wr.full    = r_full;

endmodule
`default_nettype wire
